fifo_word_packer: RTL and testbench



---
 rtl/fifo_pkg.sv | 22 ++
 rtl/pack_idle_timer.sv | 31 +++
 rtl/fifo_word_packer.sv | 123 ++++++++++++
 tb/tb_fifo_word_packer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO byte-to-word packer.
// The lane geometry here is the default one; the top derives its own from its parameters.
package fifo_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int DFLT_DATA_WIDTH = 8;
    localparam int BPW             = WORD_WIDTH / DFLT_DATA_WIDTH;

    typedef enum logic {FILL, HOLD} pack_state_t;

    // Bit-level mask covering the lowest n lanes of lane_w bits each.
    function automatic logic [WORD_WIDTH-1:0] bytes_to_mask(input int unsigned n,
                                                            input int unsigned lane_w);
        logic [WORD_WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            m[i] = ((i / lane_w) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle counter for the word packer: counts enabled cycles since the last clear.
// It pulses expire on the cycle the count reaches TIMEOUT-1. TIMEOUT=0 never expires.
module pack_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TC = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TW-1:0] idle_cnt;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idle_cnt <= '0;
        end else if (clr) begin
            idle_cnt <= '0;
        end else if (en && (idle_cnt != TC)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // A read issued this cycle wins over expiry so the incoming byte is never lost.
    assign expire = (TIMEOUT != 0) && en && !clr && (idle_cnt == TC);

endmodule

// File: rtl/fifo_word_packer.sv
// Drains bytes from the FIFO read port and packs them little-endian into 32-bit words.
// Partial words go out on flush_req or after TIMEOUT idle cycles.
//
// state | meaning
// FILL  | issuing FIFO reads and capturing bytes into lanes
// HOLD  | word presented on out_*, waiting for out_ready
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [2:0]            out_bytes,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int LANES = WORD_WIDTH / DATA_WIDTH;
    localparam int LW    = $clog2(LANES) + 1;
    localparam logic [LW-1:0] LANES_W = LW'(LANES);

    pack_state_t           state, state_nxt;
    logic [LW-1:0]         lane_cnt, lane_cnt_nxt;
    logic [LW-1:0]         in_flight;
    logic                  pend;
    logic                  flush_pend, flush_pend_nxt;
    logic [WORD_WIDTH-1:0] lanes, lanes_nxt;
    logic [2:0]            out_bytes_nxt;
    logic [CNT_WIDTH-1:0]  word_cnt_nxt;
    logic                  idle_clr, idle_en, idle_expire;

    assign in_flight = lane_cnt + LW'(pend);

    // Reads are blocked during reset so no FIFO byte is consumed and then discarded.
    assign fifo_rd_en = !PRESET && (state == FILL) && !fifo_empty &&
                        (in_flight < LANES_W) && !flush_pend;

    assign idle_clr = fifo_rd_en || pend || (state != FILL);
    assign idle_en  = (state == FILL) && (lane_cnt != '0) && !pend;

    pack_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .clr    (idle_clr),
        .en     (idle_en),
        .expire (idle_expire)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= FILL;
            lane_cnt   <= '0;
            pend       <= 1'b0;
            flush_pend <= 1'b0;
            lanes      <= '0;
            out_bytes  <= '0;
            word_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            lane_cnt   <= lane_cnt_nxt;
            pend       <= fifo_rd_en;
            flush_pend <= flush_pend_nxt;
            lanes      <= lanes_nxt;
            out_bytes  <= out_bytes_nxt;
            word_cnt   <= word_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        lane_cnt_nxt   = lane_cnt;
        flush_pend_nxt = flush_pend;
        lanes_nxt      = lanes;
        out_bytes_nxt  = out_bytes;
        word_cnt_nxt   = word_cnt;

        case (state)
            FILL: begin
                if (pend) begin
                    lanes_nxt[int'(lane_cnt)*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
                    lane_cnt_nxt = lane_cnt + 1'b1;
                end
                if (flush_req && (in_flight != '0)) begin
                    flush_pend_nxt = 1'b1;
                end
                // Full word takes priority; a flush waits for any outstanding capture.
                if (pend && (lane_cnt_nxt == LANES_W)) begin
                    state_nxt     = HOLD;
                    out_bytes_nxt = 3'(LANES);
                end else if ((flush_pend && !pend) || idle_expire) begin
                    state_nxt     = HOLD;
                    out_bytes_nxt = 3'(lane_cnt);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt      = FILL;
                    lane_cnt_nxt   = '0;
                    flush_pend_nxt = 1'b0;
                    lanes_nxt      = '0;
                    out_bytes_nxt  = '0;
                    word_cnt_nxt   = word_cnt + 1'b1;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    assign out_valid = (state == HOLD);
    assign out_data  = lanes & bytes_to_mask(32'(out_bytes), DATA_WIDTH);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer: default instance plus a TIMEOUT=0, CNT_WIDTH=4 instance.
module tb_fifo_word_packer;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    logic        fifo_empty, fifo_rd_en, flush_req, out_valid, out_ready;
    logic [7:0]  fifo_rd_data;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic [15:0] word_cnt;

    logic        fifo_empty_2, fifo_rd_en_2, flush_req_2, out_valid_2, out_ready_2;
    logic [7:0]  fifo_rd_data_2;
    logic [31:0] out_data_2;
    logic [2:0]  out_bytes_2;
    logic [3:0]  word_cnt_2;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem1 [0:255];
    logic [7:0] mem2 [0:255];
    int wr1 = 0, rd1 = 0, viol1 = 0;
    int wr2 = 0, rd2 = 0, viol2 = 0;

    fifo_word_packer dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .flush_req    (flush_req),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_bytes    (out_bytes),
        .word_cnt     (word_cnt)
    );

    fifo_word_packer #(
        .DATA_WIDTH (8),
        .TIMEOUT    (0),
        .CNT_WIDTH  (4)
    ) dut_t0 (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .fifo_empty   (fifo_empty_2),
        .fifo_rd_en   (fifo_rd_en_2),
        .fifo_rd_data (fifo_rd_data_2),
        .flush_req    (flush_req_2),
        .out_valid    (out_valid_2),
        .out_ready    (out_ready_2),
        .out_data     (out_data_2),
        .out_bytes    (out_bytes_2),
        .word_cnt     (word_cnt_2)
    );

    // FIFO models: registered read data, one byte per accepted rd_en.
    assign fifo_empty   = (wr1 == rd1);
    assign fifo_empty_2 = (wr2 == rd2);

    always @(posedge PCLK) begin
        if (fifo_rd_en) begin
            if (wr1 == rd1) viol1 <= viol1 + 1;
            else begin
                fifo_rd_data <= mem1[rd1];
                rd1 <= rd1 + 1;
            end
        end
    end

    always @(posedge PCLK) begin
        if (fifo_rd_en_2) begin
            if (wr2 == rd2) viol2 <= viol2 + 1;
            else begin
                fifo_rd_data_2 <= mem2[rd2];
                rd2 <= rd2 + 1;
            end
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[wr1] = b;
        wr1 = wr1 + 1;
    endtask

    task automatic push2(input logic [7:0] b);
        mem2[wr2] = b;
        wr2 = wr2 + 1;
    endtask

    task automatic do_reset();
        PRESET      = 1'b1;
        flush_req   = 1'b0;
        flush_req_2 = 1'b0;
        out_ready   = 1'b0;
        out_ready_2 = 1'b0;
        repeat (2) tick();
        PRESET = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 00000000", out_data); end
        total++; if (out_bytes !== 3'd0) begin bad++; $display("FAIL rst_bytes: got %0d want 0", out_bytes); end
        total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", word_cnt); end
        total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en); end
        total++; if (out_valid_2 !== 1'b0 || word_cnt_2 !== 4'd0) begin
            bad++; $display("FAIL rst_t0: valid %b cnt %0d want 0 0", out_valid_2, word_cnt_2);
        end
    endtask

    task automatic test_full_word();
        int first_v;
        logic [11:0] rd_map;
        logic [31:0] d;
        logic [2:0] nb;
        do_reset();
        out_ready = 1'b1;
        push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
        #1;
        first_v = -1; rd_map = '0; d = '0; nb = '0;
        for (int i = 0; i < 12; i++) begin
            rd_map[i] = fifo_rd_en;
            if (out_valid && first_v < 0) begin first_v = i; d = out_data; nb = out_bytes; end
            tick();
        end
        total++; if (rd_map !== 12'h00f) begin bad++; $display("FAIL full_rd_en: got %h want 00f", rd_map); end
        total++; if (first_v != 5) begin bad++; $display("FAIL full_latency: got %0d want 5", first_v); end
        total++; if (d !== 32'h44332211) begin bad++; $display("FAIL full_data: got %h want 44332211", d); end
        total++; if (nb !== 3'd4) begin bad++; $display("FAIL full_bytes: got %0d want 4", nb); end
        total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL full_cnt: got %0d want 1", word_cnt); end
    endtask

    task automatic test_backpressure();
        int first_v, second_v, hold_bad;
        logic [31:0] d2;
        do_reset();
        for (int b = 1; b <= 8; b++) push1(8'(b));
        #1;
        first_v = -1; second_v = -1; hold_bad = 0; d2 = '0;
        for (int i = 0; i < 30; i++) begin
            if (i == 15) out_ready = 1'b1;
            if (out_valid && first_v < 0) first_v = i;
            if (i >= 5 && i < 15) begin
                if (!out_valid || out_data !== 32'h04030201 || out_bytes !== 3'd4 || fifo_rd_en)
                    hold_bad++;
            end
            if (i > 15 && out_valid && second_v < 0) begin second_v = i; d2 = out_data; end
            tick();
        end
        total++; if (first_v != 5) begin bad++; $display("FAIL bp_first: got %0d want 5", first_v); end
        total++; if (hold_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", hold_bad); end
        total++; if (second_v != 21) begin bad++; $display("FAIL bp_second: got %0d want 21", second_v); end
        total++; if (d2 !== 32'h08070605) begin bad++; $display("FAIL bp_data2: got %h want 08070605", d2); end
        total++; if (word_cnt !== 16'd2) begin bad++; $display("FAIL bp_cnt: got %0d want 2", word_cnt); end
    endtask

    task automatic test_flush();
        int first_v, n_valid;
        logic [31:0] d;
        logic [2:0] nb;
        do_reset();
        out_ready = 1'b1;
        push1(8'hAA); push1(8'hBB);
        #1;
        first_v = -1; d = '0; nb = '0;
        for (int i = 0; i < 12; i++) begin
            flush_req = (i == 2);
            if (out_valid && first_v < 0) begin first_v = i; d = out_data; nb = out_bytes; end
            tick();
        end
        flush_req = 1'b0;
        total++; if (first_v != 4) begin bad++; $display("FAIL flush_latency: got %0d want 4", first_v); end
        total++; if (d !== 32'h0000BBAA) begin bad++; $display("FAIL flush_data: got %h want 0000bbaa", d); end
        total++; if (nb !== 3'd2) begin bad++; $display("FAIL flush_bytes: got %0d want 2", nb); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) n_valid++;
            tick();
        end
        total++; if (n_valid != 0) begin bad++; $display("FAIL flush_empty: got %0d valid cycles want 0", n_valid); end
        total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL flush_cnt: got %0d want 1", word_cnt); end
    endtask

    task automatic test_timeout();
        int first_v;
        logic [31:0] d;
        logic [2:0] nb;
        do_reset();
        out_ready = 1'b1;
        push1(8'h01); push1(8'h02); push1(8'h03);
        #1;
        first_v = -1; d = '0; nb = '0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid && first_v < 0) begin first_v = i; d = out_data; nb = out_bytes; end
            tick();
        end
        // last capture lands on the edge starting cycle 4, emission 16 cycles later
        total++; if (first_v != 20) begin bad++; $display("FAIL tmo_latency: got %0d want 20", first_v); end
        total++; if (d !== 32'h00030201) begin bad++; $display("FAIL tmo_data: got %h want 00030201", d); end
        total++; if (nb !== 3'd3) begin bad++; $display("FAIL tmo_bytes: got %0d want 3", nb); end
    endtask

    task automatic test_reset_mid();
        int first_v;
        logic [31:0] d;
        do_reset();
        out_ready = 1'b1;
        push1(8'hE0); push1(8'hE1); push1(8'hE2); push1(8'hE3);
        #1;
        repeat (8) tick();
        total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL mid_pre_cnt: got %0d want 1", word_cnt); end
        push1(8'hF1); push1(8'hF2); push1(8'hF3);
        #1;
        repeat (3) tick();
        #2;
        PRESET = 1'b1;
        #1;
        total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", word_cnt); end
        total++; if (out_valid !== 1'b0 || out_bytes !== 3'd0) begin
            bad++; $display("FAIL mid_outs: valid %b bytes %0d want 0 0", out_valid, out_bytes);
        end
        #3;
        PRESET = 1'b0;
        tick();
        out_ready = 1'b0;
        push1(8'h55); push1(8'h56); push1(8'h57); push1(8'h58);
        #1;
        first_v = -1; d = '0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid && first_v < 0) begin first_v = i; d = out_data; end
            tick();
        end
        total++; if (first_v != 5) begin bad++; $display("FAIL mid_fresh_lat: got %0d want 5", first_v); end
        total++; if (d !== 32'h58575655) begin bad++; $display("FAIL mid_fresh_data: got %h want 58575655", d); end
        #2;
        PRESET = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++; $display("FAIL mid_hold_drop: valid %b data %h want 0 00000000", out_valid, out_data);
        end
        tick();
        PRESET = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int hs;
        logic [31:0] last;
        do_reset();
        out_ready_2 = 1'b1;
        for (int b = 0; b < 68; b++) push2(8'(b));
        #1;
        hs = 0; last = '0;
        for (int i = 0; i < 150; i++) begin
            if (out_valid_2 && out_ready_2) begin hs++; last = out_data_2; end
            tick();
        end
        total++; if (hs != 17) begin bad++; $display("FAIL wrap_words: got %0d want 17", hs); end
        total++; if (word_cnt_2 !== 4'd1) begin bad++; $display("FAIL wrap_cnt: got %0d want 1", word_cnt_2); end
        total++; if (last !== 32'h43424140) begin bad++; $display("FAIL wrap_last: got %h want 43424140", last); end
    endtask

    task automatic test_timeout_disabled();
        int n_valid, first_v;
        logic [31:0] d;
        logic [2:0] nb;
        push2(8'h01); push2(8'h02); push2(8'h03);
        #1;
        n_valid = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid_2) n_valid++;
            tick();
        end
        total++; if (n_valid != 0) begin bad++; $display("FAIL t0_no_emit: got %0d valid cycles want 0", n_valid); end
        flush_req_2 = 1'b1;
        tick();
        flush_req_2 = 1'b0;
        first_v = -1; d = '0; nb = '0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid_2 && first_v < 0) begin first_v = i; d = out_data_2; nb = out_bytes_2; end
            tick();
        end
        total++; if (d !== 32'h00030201 || nb !== 3'd3) begin
            bad++; $display("FAIL t0_flush: got %h/%0d want 00030201/3", d, nb);
        end
        total++; if (word_cnt_2 !== 4'd2) begin bad++; $display("FAIL t0_cnt: got %0d want 2", word_cnt_2); end
    endtask

    initial begin
        PRESET      = 1'b1;
        flush_req   = 1'b0;
        flush_req_2 = 1'b0;
        out_ready   = 1'b0;
        out_ready_2 = 1'b0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_timeout_disabled();
        total++; if (viol1 != 0) begin bad++; $display("FAIL rd_when_empty: got %0d want 0", viol1); end
        total++; if (viol2 != 0) begin bad++; $display("FAIL rd_when_empty_t0: got %0d want 0", viol2); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
